mem_port_router: RTL and testbench

// - N-channel memory port router between on-chip requesters (ifmap decompressor, weight buffer,

---
 rtl/mem_port_router_pkg.sv | 16 +
 rtl/mem_tag_fifo.sv | 56 +++++
 rtl/mem_port_router.sv | 131 +++++++++++++
 tb/tb_mem_port_router.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_router_pkg.sv
// Shared types and constants for the external memory port router.
package mem_port_router_pkg;

  localparam int NUM_CH_DEF    = 3;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 64;
  localparam int TAG_DEPTH_DEF = 16;
  localparam int CH_W          = $clog2(NUM_CH_DEF);

  typedef logic [CH_W-1:0] MEM_CH_ID;

  localparam MEM_CH_ID CH_IFMAP  = MEM_CH_ID'(0);
  localparam MEM_CH_ID CH_WEIGHT = MEM_CH_ID'(1);
  localparam MEM_CH_ID CH_COMP   = MEM_CH_ID'(2);

endpackage

// File: rtl/mem_tag_fifo.sv
// Tag FIFO remembering which channel owns each outstanding read.
// A pop on an empty FIFO with a simultaneous push passes straight through.
module mem_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wen,
  input  logic [W-1:0]           wdata,
  input  logic                   ren,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  assign do_rd = ren & ~empty;
  assign do_wr = wen & ~(ren & empty) & (~full | ren);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_wr && !do_rd)      count <= count + CNT_W'(1);
      else if (do_rd && !do_wr) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_router.sv
// Round-robin router from NUM_CH requesters onto one external memory port,
// with per-channel address counters and in-order read response routing.
module mem_port_router
  import mem_port_router_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_base_addr,
  input  logic [NUM_CH-1:0]            ch_is_write,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_read_valid,
  output logic                         mem_write_valid,
  input  logic                         mem_ready,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_unexp_rsp
);

  localparam int LCH_W = $clog2(NUM_CH);
  localparam int SUM_W = LCH_W + 1;
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [LCH_W-1:0]  rr_ptr;
  logic              err_q;

  logic [LCH_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic              tag_room;
  logic [NUM_CH-1:0] elig;
  logic              sel_found;
  logic [LCH_W-1:0]  sel_idx;
  logic [SUM_W-1:0]  cand;
  logic              gnt;
  logic              rsp_pop;
  logic              rsp_hit;
  logic [LCH_W-1:0]  rsp_tag;

  // A response arriving this cycle frees the slot a new read would need.
  assign tag_room = ~fifo_full | mem_rvalid;
  assign elig     = ch_req & (ch_is_write | {NUM_CH{tag_room}});

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand >= SUM_W'(NUM_CH)) cand = cand - SUM_W'(NUM_CH);
      if (!sel_found && elig[cand[LCH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[LCH_W-1:0];
      end
    end
  end

  assign gnt             = sel_found & mem_ready & ~start & ~rst;
  assign mem_addr        = gnt ? addr_q[sel_idx] : '0;
  assign mem_wdata       = gnt ? ch_wdata[sel_idx*DATA_W +: DATA_W] : '0;
  assign mem_read_valid  = gnt & ~ch_is_write[sel_idx];
  assign mem_write_valid = gnt & ch_is_write[sel_idx];

  // An empty FIFO with a same-cycle read issue routes the response to the new tag.
  assign rsp_pop = mem_rvalid & ~start & ~rst;
  assign rsp_hit = rsp_pop & (~fifo_empty | mem_read_valid);
  assign rsp_tag = fifo_empty ? sel_idx : fifo_head;

  always_comb begin
    ch_ack    = '0;
    ch_rvalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack[i]    = gnt && (sel_idx == LCH_W'(i));
      ch_rvalid[i] = rsp_hit && (rsp_tag == LCH_W'(i));
    end
  end

  assign ch_rdata      = rst ? '0 : mem_rdata;
  assign outstanding   = fifo_count;
  assign err_unexp_rsp = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) addr_q[i] <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < NUM_CH; i++) addr_q[i] <= ch_base_addr[i*ADDR_W +: ADDR_W];
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (gnt) begin
        addr_q[sel_idx] <= addr_q[sel_idx] + ADDR_W'(1);
        rr_ptr <= (sel_idx == LCH_W'(NUM_CH - 1)) ? '0 : sel_idx + LCH_W'(1);
      end
      if (rsp_pop && !rsp_hit) err_q <= 1'b1;
    end
  end

  mem_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (LCH_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .wen   (mem_read_valid),
    .wdata (sel_idx),
    .ren   (rsp_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_router.sv
// Directed plus randomized bench for mem_port_router against a queue-based reference model.
module tb_mem_port_router;
  import mem_port_router_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int DW  = 64;
  localparam int TD  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NCH*AW-1:0] ch_base_addr;
  logic [NCH-1:0]    ch_is_write;
  logic [NCH-1:0]    ch_req;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_ack;
  logic [DW-1:0]     ch_rdata;
  logic [NCH-1:0]    ch_rvalid;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_read_valid;
  logic              mem_write_valid;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic              mem_rvalid;
  logic [4:0]        outstanding;
  logic              err_unexp_rsp;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] m_addr [NCH];
  int            m_rr;
  int            m_q [$];
  bit            m_err;

  logic [NCH-1:0] obs_ack;
  logic [NCH-1:0] obs_rv;
  logic [AW-1:0]  obs_addr;
  logic [DW-1:0]  obs_rdata;
  logic [4:0]     obs_out;
  logic           obs_err;

  always #5 clk = ~clk;

  mem_port_router #(
    .NUM_CH    (NCH),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TAG_DEPTH (TD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .ch_base_addr    (ch_base_addr),
    .ch_is_write     (ch_is_write),
    .ch_req          (ch_req),
    .ch_wdata        (ch_wdata),
    .ch_ack          (ch_ack),
    .ch_rdata        (ch_rdata),
    .ch_rvalid       (ch_rvalid),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_read_valid  (mem_read_valid),
    .mem_write_valid (mem_write_valid),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .outstanding     (outstanding),
    .err_unexp_rsp   (err_unexp_rsp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_addr[i] = '0;
    m_rr = 0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g;
    int c;
    logic [NCH-1:0] e_ack;
    logic [NCH-1:0] e_rv;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_wd;
    bit e_r;
    bit e_w;
    @(negedge clk);
    g = -1; e_ack = '0; e_rv = '0; e_addr = '0; e_wd = '0; e_r = 0; e_w = 0;
    if (!rst) begin
      if (!start && mem_ready) begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (g < 0 && ch_req[c] && (ch_is_write[c] || m_q.size() < TD || mem_rvalid)) g = c;
        end
      end
      if (g >= 0) begin
        e_ack[g] = 1'b1;
        e_addr   = m_addr[g];
        e_wd     = ch_wdata[g*DW +: DW];
        e_r      = !ch_is_write[g];
        e_w      = ch_is_write[g];
      end
      if (mem_rvalid && !start) begin
        if (m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
        else if (e_r)       e_rv[g] = 1'b1;
      end
    end
    obs_ack = ch_ack; obs_rv = ch_rvalid; obs_addr = mem_addr;
    obs_rdata = ch_rdata; obs_out = outstanding; obs_err = err_unexp_rsp;
    chk("ack",   64'(ch_ack), 64'(e_ack));
    chk("addr",  64'(mem_addr), 64'(e_addr));
    chk("wdata", mem_wdata, e_wd);
    chk("rd_v",  64'(mem_read_valid), 64'(e_r));
    chk("wr_v",  64'(mem_write_valid), 64'(e_w));
    chk("rvalid", 64'(ch_rvalid), 64'(e_rv));
    if (rst) chk("rdata_rst", ch_rdata, 64'd0);
    else if (e_rv != '0) chk("rdata", ch_rdata, mem_rdata);
    chk("outstanding", 64'(outstanding), rst ? 64'd0 : 64'(m_q.size()));
    chk("err", 64'(err_unexp_rsp), rst ? 64'd0 : 64'(m_err));
    @(posedge clk);
    if (rst) model_reset();
    else if (start) begin
      for (int i = 0; i < NCH; i++) m_addr[i] = ch_base_addr[i*AW +: AW];
      m_rr = 0;
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (mem_rvalid && m_q.size() > 0) begin
        void'(m_q.pop_front());
        if (e_r) m_q.push_back(g);
      end else if (mem_rvalid && !e_r) begin
        m_err = 1'b1;
      end else if (!mem_rvalid && e_r) begin
        m_q.push_back(g);
      end
      if (g >= 0) begin
        m_addr[g] = m_addr[g] + AW'(1);
        m_rr = (g + 1) % NCH;
      end
    end
    #1;
  endtask

  initial begin
    logic [NCH-1:0] rot_ack  [6];
    logic [AW-1:0]  rot_addr [6];
    logic [DW-1:0]  d [3];
    int ch0_cnt;
    rot_ack  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rot_addr = '{16'h100, 16'h200, 16'h300, 16'h101, 16'h201, 16'h301};
    model_reset();
    rst = 1'b1; start = 1'b0; ch_base_addr = '0; ch_is_write = '0; ch_req = '0;
    ch_wdata = '0; mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) cycle();

    // rotation across three channels
    rst = 1'b0; start = 1'b1;
    ch_base_addr = {16'h300, 16'h200, 16'h100}; ch_is_write = 3'b100;
    cycle();
    start = 1'b0; ch_req = 3'b111; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ch_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle();
      chk("rot_ack", 64'(obs_ack), 64'(rot_ack[i]));
      chk("rot_addr", 64'(obs_addr), 64'(rot_addr[i]));
    end

    // back-pressure freezes everything
    mem_ready = 1'b0;
    repeat (5) cycle();
    mem_ready = 1'b1;
    cycle();
    chk("release_ack", 64'(obs_ack), 64'(3'b001));
    chk("release_addr", 64'(obs_addr), 64'h102);
    repeat (2) cycle();

    // tag FIFO fills at 16 reads while writes continue
    ch_req = '0; start = 1'b1;
    cycle();
    start = 1'b0; ch_req = 3'b101; ch0_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_ack[CH_IFMAP]) ch0_cnt++;
    end
    chk("fill_ch0_acks", 64'(ch0_cnt), 64'd16);
    chk("fill_outstanding", 64'(obs_out), 64'd16);
    mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom};
    cycle();
    chk("full_pop_ack", 64'(obs_ack), 64'(3'b001));
    chk("full_pop_rv", 64'(obs_rv), 64'(3'b001));
    ch_req = '0;
    for (int i = 0; i < 16; i++) begin
      mem_rdata = {$urandom, $urandom};
      cycle();
    end
    mem_rvalid = 1'b0;
    cycle();
    chk("drain_outstanding", 64'(obs_out), 64'd0);

    // interleaved reads, responses routed in order
    start = 1'b1;
    cycle();
    start = 1'b0;
    ch_req = 3'b001; cycle();
    ch_req = 3'b010; cycle();
    ch_req = 3'b001; cycle();
    ch_req = '0;
    d = '{64'hD0D0_0000_0000_00D0, 64'hD1D1_1111_1111_11D1, 64'hD2D2_2222_2222_22D2};
    mem_rvalid = 1'b1;
    mem_rdata = d[0]; cycle();
    chk("il_rv0", 64'(obs_rv), 64'(3'b001)); chk("il_d0", obs_rdata, d[0]);
    mem_rdata = d[1]; cycle();
    chk("il_rv1", 64'(obs_rv), 64'(3'b010)); chk("il_d1", obs_rdata, d[1]);
    mem_rdata = d[2]; cycle();
    chk("il_rv2", 64'(obs_rv), 64'(3'b001)); chk("il_d2", obs_rdata, d[2]);
    mem_rvalid = 1'b0;
    cycle();
    chk("il_outstanding", 64'(obs_out), 64'd0);

    // unexpected response is sticky until start
    mem_rvalid = 1'b1; cycle();
    chk("unexp_rv", 64'(obs_rv), 64'd0);
    mem_rvalid = 1'b0;
    repeat (3) cycle();
    chk("unexp_err", 64'(obs_err), 64'd1);
    start = 1'b1; cycle();
    start = 1'b0; cycle();
    chk("unexp_cleared", 64'(obs_err), 64'd0);

    // start while reads are in flight
    ch_req = 3'b001;
    repeat (4) cycle();
    ch_req = 3'b111; start = 1'b1;
    ch_base_addr = {16'h0030, 16'h0020, 16'h0010};
    cycle();
    chk("start_no_ack", 64'(obs_ack), 64'd0);
    start = 1'b0; ch_req = '0;
    cycle();
    chk("start_flush", 64'(obs_out), 64'd0);
    mem_rvalid = 1'b1; cycle();
    mem_rvalid = 1'b0; cycle();
    chk("stale_rsp_err", 64'(obs_err), 64'd1);
    ch_req = 3'b001; cycle();
    chk("restart_addr", 64'(obs_addr), 64'h0010);
    ch_req = '0;

    // randomized traffic, including address wrap and mid-run resets
    for (int n = 0; n < 500; n++) begin
      rst = 1'b0; start = 1'b0;
      if ($urandom_range(99) < 2) begin
        start = 1'b1;
        ch_base_addr = {16'($urandom), 16'hFFFE, 16'($urandom)};
        ch_is_write = 3'($urandom);
      end else if ($urandom_range(199) == 0) begin
        rst = 1'b1;
      end
      ch_req    = 3'($urandom);
      mem_ready = ($urandom_range(3) != 0);
      ch_wdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      mem_rvalid = (m_q.size() > 0) ? ($urandom_range(9) < 7) : ($urandom_range(99) < 3);
      cycle();
    end
    rst = 1'b0; start = 1'b0; ch_req = '0; mem_rvalid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
